// File: rtl/tt_sweeper_if.sv
// ============================================================================
//  Module      : tt_sweeper_if
//  Description : Control, result and gate-side signals of the truth-table
//                sweeper, bundled with initiator/sweeper modports.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tt_sweeper_if #(
    parameter int N_IN = 4
);
    localparam int TW = 1 << N_IN;

    logic              start;
    logic [TW-1:0]     expected;
    logic [N_IN-1:0]   gate_in;
    logic              gate_out;
    logic              busy;
    logic              done;
    logic [TW-1:0]     tt;
    logic              match;
    logic [N_IN:0]     mismatch_count;
    logic [N_IN-1:0]   first_fail;
    logic              unstable;

    // Initiator side: issues start/expected and models the gate under test.
    modport master (
        output start,
        output expected,
        output gate_out,
        input  gate_in,
        input  busy,
        input  done,
        input  tt,
        input  match,
        input  mismatch_count,
        input  first_fail,
        input  unstable
    );

    modport slave (
        input  start,
        input  expected,
        input  gate_out,
        output gate_in,
        output busy,
        output done,
        output tt,
        output match,
        output mismatch_count,
        output first_fail,
        output unstable
    );
endinterface

`default_nettype wire

// File: rtl/tt_sweeper.sv
// ============================================================================
//  Module      : tt_sweeper
//  Description : Walks every input vector through a combinational gate,
//                samples its response and checks it against an expected table.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_sweeper #(
    parameter int N_IN    = 4,
    parameter int SETTLE  = 2,
    parameter int SAMPLES = 3
) (
    input  wire logic    clk,
    input  wire logic    rst,
    tt_sweeper_if.slave  bus
);
    localparam int TW   = 1 << N_IN;
    localparam int MAXC = (SETTLE > SAMPLES) ? SETTLE : SAMPLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    logic [N_IN-1:0]    r_vec;
    logic [CW-1:0]      r_cnt;
    logic [TW-1:0]      r_exp;
    logic [TW-1:0]      r_tt;
    logic               r_first_bit;
    logic [N_IN:0]      r_mcount;
    logic [N_IN-1:0]    r_ffail;
    logic               r_found;
    logic               r_unst;
    logic               r_match;
    logic               r_busy;
    logic               r_done;
    logic [N_IN-1:0]    r_gate_in;

    // Vector v lives at bit TW-1-v, which is simply the bitwise inverse of v.
    logic [N_IN-1:0]    w_idx;
    logic               w_exp_bit;
    logic               w_first;
    logic               w_miss;
    logic [N_IN:0]      w_mcount_next;
    logic               w_last_vec;
    logic               w_settle_end;
    logic               w_sample_end;

    always_comb begin
        w_idx         = ~r_vec;
        w_exp_bit     = r_exp[w_idx];
        w_first       = (r_cnt == '0);
        w_miss        = w_first && (bus.gate_out != w_exp_bit);
        w_mcount_next = r_mcount + {{N_IN{1'b0}}, w_miss};
        w_last_vec    = &r_vec;
        w_settle_end  = (r_cnt == CW'(SETTLE - 1));
        w_sample_end  = (r_cnt == CW'(SAMPLES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_vec       <= '0;
            r_cnt       <= '0;
            r_exp       <= '0;
            r_tt        <= '0;
            r_first_bit <= 1'b0;
            r_mcount    <= '0;
            r_ffail     <= '0;
            r_found     <= 1'b0;
            r_unst      <= 1'b0;
            r_match     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_gate_in   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_exp     <= bus.expected;
                        r_tt      <= '0;
                        r_mcount  <= '0;
                        r_ffail   <= '0;
                        r_found   <= 1'b0;
                        r_unst    <= 1'b0;
                        r_match   <= 1'b0;
                        r_vec     <= '0;
                        r_cnt     <= '0;
                        r_gate_in <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    if (w_settle_end) begin
                        r_cnt   <= '0;
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_SAMPLE: begin
                    // The first sample is the recorded result; later samples
                    // only feed the stability flag.
                    if (w_first) begin
                        r_first_bit <= bus.gate_out;
                        r_tt[w_idx] <= bus.gate_out;
                        r_mcount    <= w_mcount_next;
                        if (w_miss && !r_found) begin
                            r_ffail <= r_vec;
                            r_found <= 1'b1;
                        end
                    end else if (bus.gate_out != r_first_bit) begin
                        r_unst <= 1'b1;
                    end

                    if (w_sample_end) begin
                        r_cnt <= '0;
                        if (w_last_vec) begin
                            r_match   <= (w_mcount_next == '0);
                            r_done    <= 1'b1;
                            r_busy    <= 1'b0;
                            r_gate_in <= '0;
                            r_state   <= S_DONE;
                        end else begin
                            r_vec     <= r_vec + 1'b1;
                            r_gate_in <= r_vec + 1'b1;
                            r_state   <= S_SETTLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gate_in        = r_gate_in;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.tt             = r_tt;
    assign bus.match          = r_match;
    assign bus.mismatch_count = r_mcount;
    assign bus.first_fail     = r_ffail;
    assign bus.unstable       = r_unst;

endmodule

`default_nettype wire

// File: tb/tb_tt_sweeper.sv
// ============================================================================
//  Module      : tb_tt_sweeper
//  Description : Directed self-checking bench for tt_sweeper with a
//                sample-log based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_sweeper;
    localparam int N    = 4;
    localparam int TW   = 16;
    localparam int ST   = 2;
    localparam int SM   = 3;
    localparam int PER  = ST + SM;
    localparam int LAST = TW * PER;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tt_sweeper_if #(.N_IN(N)) bus ();

    tt_sweeper #(.N_IN(N), .SETTLE(ST), .SAMPLES(SM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Gate model: 0 = 0x5AAD gate, 1 = output tied low, 2 = 0x5AAD gate with
    // a toggling glitch whenever vector 6 is applied.
    logic [15:0] c_gate_tt = 16'h5AAD;
    int          mode      = 0;
    logic        tog       = 1'b0;

    initial forever begin
        @(posedge clk);
        #1 tog = ~tog;
    end

    assign bus.gate_out = (mode == 1) ? 1'b0 :
        (c_gate_tt[~bus.gate_in] ^ ((mode == 2) && (bus.gate_in == 4'd6) && tog));

    logic        s_log [0:LAST+1];
    logic [15:0] m_tt;
    int          m_cnt;
    int          m_ff;
    logic        m_unst;
    int          ndone;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: vector v is sampled on edges PER*v+ST+1 .. PER*v+ST+SM
    // after the start edge; the first of those is the recorded bit.
    task automatic build_model(input logic [15:0] exp_tt);
        logic first;
        m_tt = '0; m_cnt = 0; m_ff = -1; m_unst = 1'b0;
        for (int v = 0; v < TW; v++) begin
            first = s_log[PER*v + ST + 1];
            for (int j = 1; j < SM; j++)
                if (s_log[PER*v + ST + 1 + j] != first) m_unst = 1'b1;
            m_tt[15-v] = first;
            if (first != exp_tt[15-v]) begin
                m_cnt++;
                if (m_ff < 0) m_ff = v;
            end
        end
        if (m_ff < 0) m_ff = 0;
    endtask

    task automatic check_results(input string tag);
        chk({tag, ".tt"},    32'(bus.tt),             32'(m_tt));
        chk({tag, ".match"}, 32'(bus.match),          32'(m_cnt == 0));
        chk({tag, ".mcnt"},  32'(bus.mismatch_count), 32'(m_cnt));
        chk({tag, ".ffail"}, 32'(bus.first_fail),     32'(m_ff));
        chk({tag, ".unst"},  32'(bus.unstable),       32'(m_unst));
    endtask

    task automatic run_sweep(input logic [15:0] exp_tt, input bit rep);
        int gi;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.expected = exp_tt;
        @(posedge clk);
        ndone = 0;
        for (int k = 0; k <= LAST + 4; k++) begin
            @(negedge clk);
            bus.start = rep && (((k % 3 == 0) && (k < LAST - 2)) || (k == LAST));
            if (k < LAST) s_log[k+1] = bus.gate_out;
            gi = (k < LAST) ? k / PER : 0;
            chk("busy",    32'(bus.busy),    32'(k < LAST));
            chk("done",    32'(bus.done),    32'(k == LAST));
            chk("gate_in", 32'(bus.gate_in), 32'(gi));
            if (bus.done) ndone++;
            if (k == LAST) begin
                build_model(exp_tt);
                check_results("done");
            end
            if (k == LAST + 4) check_results("persist");
        end
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.expected = '0;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.busy",  32'(bus.busy), 0);
        chk("rst.done",  32'(bus.done), 0);
        chk("rst.gi",    32'(bus.gate_in), 0);
        chk("rst.tt",    32'(bus.tt), 0);
        chk("rst.match", 32'(bus.match), 0);
        chk("rst.mcnt",  32'(bus.mismatch_count), 0);
        chk("rst.ffail", 32'(bus.first_fail), 0);
        chk("rst.unst",  32'(bus.unstable), 0);
        rst = 1'b0;

        // Matching sweep of the 0x5AAD gate.
        mode = 0;
        run_sweep(16'h5AAD, 1'b0);
        chk("t1.tt_lit",   32'(bus.tt), 32'h5AAD);
        chk("t1.v0_7",     32'(m_tt[15:8]), 32'b0101_1010);
        chk("t1.match",    32'(bus.match), 1);
        chk("t1.mcnt",     32'(bus.mismatch_count), 0);
        chk("t1.unst",     32'(bus.unstable), 0);
        chk("t1.ndone",    32'(ndone), 1);

        run_sweep(16'h5AAC, 1'b0);
        chk("t2.match", 32'(bus.match), 0);
        chk("t2.mcnt",  32'(bus.mismatch_count), 1);
        chk("t2.ffail", 32'(bus.first_fail), 15);

        run_sweep(16'hDAAD, 1'b0);
        chk("t3.mcnt",  32'(bus.mismatch_count), 1);
        chk("t3.ffail", 32'(bus.first_fail), 0);

        // Output stuck low against an all-ones expectation.
        mode = 1;
        run_sweep(16'hFFFF, 1'b0);
        chk("t4.tt",    32'(bus.tt), 0);
        chk("t4.mcnt",  32'(bus.mismatch_count), 16);
        chk("t4.ffail", 32'(bus.first_fail), 0);
        chk("t4.match", 32'(bus.match), 0);

        // Glitching vector 6.
        mode = 2;
        run_sweep(16'h5AAD, 1'b0);
        chk("t5.unst",  32'(bus.unstable), 1);
        chk("t5.other", 32'({bus.tt[15:10], bus.tt[8:0]}), 32'({6'b010110, 9'h0AD}));
        chk("t5.bit9",  32'(bus.tt[9]), 32'(s_log[PER*6 + ST + 1]));

        // Reset during a sweep.
        mode = 0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.expected = 16'h5AAD;
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k == 39) rst = 1'b1;
        end
        @(negedge clk);
        chk("abort.busy",  32'(bus.busy), 0);
        chk("abort.gi",    32'(bus.gate_in), 0);
        chk("abort.tt",    32'(bus.tt), 0);
        chk("abort.mcnt",  32'(bus.mismatch_count), 0);
        chk("abort.ffail", 32'(bus.first_fail), 0);
        chk("abort.unst",  32'(bus.unstable), 0);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) ndone++;
        end
        chk("abort.quiet", 32'(ndone), 0);

        run_sweep(16'h5AAD, 1'b0);
        chk("fresh.tt", 32'(bus.tt), 32'h5AAD);

        // Repeated start pulses while busy and during the done cycle.
        run_sweep(16'h5AAD, 1'b1);
        chk("rep.ndone", 32'(ndone), 1);
        chk("rep.tt",    32'(bus.tt), 32'h5AAD);
        chk("rep.match", 32'(bus.match), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
